// File: rtl/mem_pkg.sv
// mem_pkg: shared access-size and responder state encodings
package mem_pkg;
  typedef enum logic [1:0] {
    SizeByte = 2'b00,
    SizeHalf = 2'b01,
    SizeWord = 2'b10
  } size_e;
  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StWait = 2'b01,
    StResp = 2'b10
  } state_e;
endpackage

// File: rtl/load_ext.sv
// load_ext: selects the addressed lane(s) of a word, right-aligns and extends them
module load_ext
  import mem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  lane_i,
  input  size_e       size_i,
  input  logic        unsigned_i,
  output logic [31:0] data_o
);
  logic [7:0]  b;
  logic [15:0] h;
  logic [31:0] bs, hs;
  assign b = word_i[8*lane_i +: 8];
  assign h = lane_i[1] ? word_i[31:16] : word_i[15:0];
  sign_ext #(.InW(8))  u_sx_b (.data_i(b), .data_o(bs));
  sign_ext #(.InW(16)) u_sx_h (.data_i(h), .data_o(hs));
  // word loads ignore the unsigned flag; narrower loads pick zero or sign extension
  always_comb
    data_o = size_i == SizeByte ? (unsigned_i ? {24'b0, b} : bs) :
             size_i == SizeHalf ? (unsigned_i ? {16'b0, h} : hs) : word_i;
endmodule

// File: rtl/sign_ext.sv
// sign_ext: sign-extends an InW-bit value to 32 bits
module sign_ext #(
  parameter int InW = 8
) (
  input  logic [InW-1:0] data_i,
  output logic [31:0]    data_o
);
  assign data_o = {{(32 - InW){data_i[InW-1]}}, data_i};
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: valid/ready data-memory slave with fixed wait states and byte-lane access
module dmem_responder
  import mem_pkg::*;
#(
  parameter int Depth      = 256,
  parameter int WaitCycles = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o
);
  localparam int AW = Depth > 1 ? $clog2(Depth) : 1;
  state_e      state, state_nx;
  logic [31:0] cnt;
  logic        l_write, l_uns;
  logic [31:0] l_addr, l_wdata;
  logic [1:0]  l_size;
  logic [31:0] mem [Depth];
  logic        accept, access, err;
  logic        a_write, a_uns;
  logic [31:0] a_addr, a_wdata, wd, ld;
  logic [1:0]  a_size;
  logic [AW-1:0] idx;
  logic [3:0]  be;
  assign req_ready_o  = state == StIdle;
  assign resp_valid_o = state == StResp;
  assign accept       = req_valid_i && req_ready_o;
  // with zero wait states the access happens straight from the request inputs
  assign a_write = state == StIdle ? req_write_i    : l_write;
  assign a_addr  = state == StIdle ? req_addr_i     : l_addr;
  assign a_wdata = state == StIdle ? req_wdata_i    : l_wdata;
  assign a_size  = state == StIdle ? req_size_i     : l_size;
  assign a_uns   = state == StIdle ? req_unsigned_i : l_uns;
  assign idx     = a_addr[AW+1:2];
  assign err = a_size == 2'b11 || (a_size == SizeHalf && a_addr[0]) ||
               (a_size == SizeWord && a_addr[1:0] != 2'b00) || a_addr[31:2] >= 30'(Depth);
  assign be = a_size == SizeByte ? 4'b0001 << a_addr[1:0] :
              a_size == SizeHalf ? 4'b0011 << a_addr[1:0] : 4'b1111;
  assign wd = a_size == SizeByte ? {4{a_wdata[7:0]}} :
              a_size == SizeHalf ? {2{a_wdata[15:0]}} : a_wdata;
  load_ext u_load_ext (
    .word_i    (mem[idx]),
    .lane_i    (a_addr[1:0]),
    .size_i    (size_e'(a_size)),
    .unsigned_i(a_uns),
    .data_o    (ld)
  );
  // next state and the single access strobe that commits stores and captures load data
  always_comb begin
    state_nx = state;
    access   = 1'b0;
    case (state)
      StIdle: if (accept) begin
        state_nx = WaitCycles == 0 ? StResp : StWait;
        access   = WaitCycles == 0;
      end
      StWait: if (cnt == 0) begin
        state_nx = StResp;
        access   = 1'b1;
      end
      StResp: if (resp_ready_i) state_nx = StIdle;
      default: state_nx = StIdle;
    endcase
  end
  // state, wait counter, request latch and registered response
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state        <= StIdle;
      cnt          <= '0;
      resp_rdata_o <= '0;
      resp_err_o   <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        l_write <= req_write_i;
        l_addr  <= req_addr_i;
        l_wdata <= req_wdata_i;
        l_size  <= req_size_i;
        l_uns   <= req_unsigned_i;
        cnt     <= 32'(WaitCycles - 1);
      end else if (state == StWait && cnt != 0) begin
        cnt <= cnt - 1;
      end
      if (access) begin
        resp_rdata_o <= (err || a_write) ? '0 : ld;
        resp_err_o   <= err;
      end
    end
  end
  // byte-enabled store commit; reset gates it so an aborted store never lands
  always_ff @(posedge clk_i) begin
    if (rst_ni && access && a_write && !err)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[idx][8*i +: 8] <= wd[8*i +: 8];
  end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed and randomized checks against a byte-array reference model
module tb_dmem_responder;
  localparam int Depth = 256;
  localparam int WaitCycles = 2;
  logic clk_i = 1'b0, rst_ni = 1'b0;
  logic req_valid_i = 1'b0, req_write_i = 1'b0, req_unsigned_i = 1'b0, resp_ready_i = 1'b0;
  logic [31:0] req_addr_i = '0, req_wdata_i = '0;
  logic [1:0]  req_size_i = '0;
  logic req_ready_o, resp_valid_o, resp_err_o;
  logic [31:0] resp_rdata_o;
  int checks = 0, failures = 0;
  logic [7:0] ref_mem [Depth*4];

  dmem_responder #(.Depth(Depth), .WaitCycles(WaitCycles)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_write_i(req_write_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .req_size_i(req_size_i), .req_unsigned_i(req_unsigned_i), .resp_valid_o(resp_valid_o),
    .resp_ready_i(resp_ready_i), .resp_rdata_o(resp_rdata_o), .resp_err_o(resp_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic w, input logic [31:0] a, input logic [31:0] d,
                                input logic [1:0] s, input logic u,
                                output logic [31:0] r, output logic e);
    int nb;
    nb = s == 2'd0 ? 1 : s == 2'd1 ? 2 : 4;
    e = s == 2'd3 || (a % nb) != 0 || (a / 4) >= Depth;
    r = '0;
    if (!e) begin
      for (int n = 0; n < nb; n++)
        if (w) ref_mem[int'(a) + n] = d[8*n +: 8];
        else   r[8*n +: 8] = ref_mem[int'(a) + n];
      if (!w && !u && nb < 4 && r[8*nb-1]) r = r | ~((32'h1 << (8*nb)) - 1);
    end
  endfunction

  task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [1:0] s, input logic u, input int hold, input bit poke,
                     output logic [31:0] r_obs, output logic e_obs);
    logic [31:0] er;
    logic ee;
    int n;
    model(w, a, d, s, u, er, ee);
    n = 0;
    while (!req_ready_o && n < 20) begin @(posedge clk_i); #1; n++; end
    chk("req_ready_idle", {31'b0, req_ready_o}, 1);
    req_valid_i = 1; req_write_i = w; req_addr_i = a; req_wdata_i = d;
    req_size_i = s; req_unsigned_i = u;
    @(posedge clk_i); #1;
    req_valid_i = 0;
    n = 0;
    while (!resp_valid_o && n < 20) begin @(posedge clk_i); #1; n++; end
    chk("latency", n, WaitCycles);
    chk("rdata", resp_rdata_o, er);
    chk("err", {31'b0, resp_err_o}, {31'b0, ee});
    chk("req_ready_in_resp", {31'b0, req_ready_o}, 0);
    r_obs = resp_rdata_o; e_obs = resp_err_o;
    for (int i = 0; i < hold; i++) begin
      if (poke && i == 1) begin
        req_valid_i = 1; req_write_i = 1; req_addr_i = 32'h10; req_wdata_i = 32'hA5A5A5A5;
        req_size_i = 2'd2;
      end
      @(posedge clk_i); #1;
      req_valid_i = 0;
      chk("hold_valid", {31'b0, resp_valid_o}, 1);
      chk("hold_rdata", resp_rdata_o, er);
      chk("hold_err", {31'b0, resp_err_o}, {31'b0, ee});
      chk("hold_req_ready", {31'b0, req_ready_o}, 0);
    end
    resp_ready_i = 1;
    @(posedge clk_i); #1;
    resp_ready_i = 0;
    chk("resp_done", {31'b0, resp_valid_o}, 0);
    chk("idle_again", {31'b0, req_ready_o}, 1);
  endtask

  initial begin
    logic [31:0] r, prior, a;
    logic e;
    int idx;
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_req_ready", {31'b0, req_ready_o}, 1);
    chk("rst_resp_valid", {31'b0, resp_valid_o}, 0);
    chk("rst_rdata", resp_rdata_o, 0);
    chk("rst_err", {31'b0, resp_err_o}, 0);
    rst_ni = 1;
    for (int i = 0; i < 64; i++) txn(1, 32'(i * 4), $urandom, 2'd2, 0, 0, 0, r, e);
    txn(1, 32'h10, 32'hDEADBEEF, 2'd2, 0, 0, 0, r, e);
    txn(0, 32'h10, 0, 2'd2, 0, 0, 0, r, e);
    chk("d_word", r, 32'hDEADBEEF);
    txn(0, 32'h13, 0, 2'd0, 0, 0, 0, r, e);
    chk("d_byte_s", r, 32'hFFFFFFDE);
    txn(0, 32'h13, 0, 2'd0, 1, 0, 0, r, e);
    chk("d_byte_u", r, 32'h000000DE);
    txn(0, 32'h10, 0, 2'd1, 0, 0, 0, r, e);
    chk("d_half_s", r, 32'hFFFFBEEF);
    txn(1, 32'h11, 32'h55, 2'd0, 0, 0, 0, r, e);
    txn(0, 32'h10, 0, 2'd2, 0, 0, 0, r, e);
    chk("d_byte_merge", r, 32'hDEAD55EF);
    txn(0, 32'h11, 0, 2'd1, 0, 0, 0, r, e);
    chk("d_err_half", {r[30:0], e}, 32'h1);
    txn(0, 32'h12, 0, 2'd2, 0, 0, 0, r, e);
    chk("d_err_word", {r[30:0], e}, 32'h1);
    txn(1, 32'h0, 32'hFFFFFFFF, 2'd3, 0, 0, 0, r, e);
    chk("d_err_size", {r[30:0], e}, 32'h1);
    txn(1, 32'h400, 32'h0, 2'd2, 0, 0, 0, r, e);
    chk("d_err_range", {r[30:0], e}, 32'h1);
    txn(0, 32'h10, 0, 2'd2, 0, 5, 1, r, e);
    chk("d_hold_word", r, 32'hDEAD55EF);
    txn(0, 32'h10, 0, 2'd2, 0, 0, 0, r, e);
    chk("d_poke_ignored", r, 32'hDEAD55EF);
    prior = {ref_mem[35], ref_mem[34], ref_mem[33], ref_mem[32]};
    req_valid_i = 1; req_write_i = 1; req_addr_i = 32'h20; req_wdata_i = 32'h12345678;
    req_size_i = 2'd2; req_unsigned_i = 0;
    @(posedge clk_i); #1;
    req_valid_i = 0; rst_ni = 0;
    @(posedge clk_i); #1;
    chk("wrst_req_ready", {31'b0, req_ready_o}, 1);
    chk("wrst_resp_valid", {31'b0, resp_valid_o}, 0);
    chk("wrst_rdata", resp_rdata_o, 0);
    chk("wrst_err", {31'b0, resp_err_o}, 0);
    repeat (3) begin
      @(posedge clk_i); #1;
      chk("wrst_hold_valid", {31'b0, resp_valid_o}, 0);
    end
    rst_ni = 1;
    txn(0, 32'h20, 0, 2'd2, 0, 0, 0, r, e);
    chk("d_aborted_store", r, prior);
    for (int k = 0; k < 150; k++) begin
      idx = $urandom_range(0, 9) == 0 ? int'($urandom_range(Depth, 1 << 20)) : int'($urandom_range(0, 63));
      a = {idx[29:0], 2'($urandom_range(0, 3))};
      txn(1'($urandom_range(0, 1)), a, $urandom, 2'($urandom_range(0, 3)),
          1'($urandom_range(0, 1)), $urandom_range(0, 3), 0, r, e);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL have parameter Depth, default 256, meaning the number of 32-bit memory words.
REQ-002 The block SHALL have parameter WaitCycles, default 2, meaning the number of wait states between accept and access (0 allowed).
REQ-003 The block SHALL have port clk_i, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst_ni, input, 1 bit: synchronous, active-low reset.
REQ-005 The block SHALL have port req_valid_i, input, 1 bit: request present.
REQ-006 The block SHALL have port req_ready_o, output, 1 bit: responder can accept a request.
REQ-007 The block SHALL have port req_write_i, input, 1 bit: 1 means store, 0 means load.
REQ-008 The block SHALL have port req_addr_i, input, 32 bits: byte address.
REQ-009 The block SHALL have port req_wdata_i, input, 32 bits: store data, right-aligned.
REQ-010 The block SHALL have port req_size_i, input, 2 bits: 00 byte, 01 half, 10 word, 11 illegal.
REQ-011 The block SHALL have port req_unsigned_i, input, 1 bit: zero-extend loads; sign-extend when 0.
REQ-012 The block SHALL have port resp_valid_o, output, 1 bit: response present.
REQ-013 The block SHALL have port resp_ready_i, input, 1 bit: requester accepts the response.
REQ-014 The block SHALL have port resp_rdata_o, output, 32 bits: extended load data; 0 for stores and errors.
REQ-015 The block SHALL have port resp_err_o, output, 1 bit: access fault; qualified by resp_valid_o.

Function
REQ-016 The FSM SHALL have states IDLE, WAIT and RESP; req_ready_o SHALL be 1 only in IDLE.
REQ-017 In IDLE, when req_valid_i=1 and req_ready_o=1, the block SHALL latch write, addr, wdata, size and unsigned, then enter WAIT, or enter RESP directly if WaitCycles=0.
REQ-018 In WAIT, a down-counter loaded with WaitCycles-1 SHALL decrement each cycle; at 0 the block SHALL perform the access and enter RESP.
REQ-019 When a request is accepted in cycle T, resp_valid_o SHALL first be 1 in cycle T+WaitCycles+1.
REQ-020 In RESP, resp_valid_o=1 and resp_rdata_o/resp_err_o SHALL stay stable until resp_ready_i=1; that cycle the block SHALL return to IDLE.
REQ-021 No new request SHALL be accepted in the response-handshake cycle; the earliest next accept is the following cycle.
REQ-022 Word index SHALL be addr[31:2] and the byte lane addr[1:0], little-endian.
REQ-023 A store SHALL update only the addressed lanes with a per-byte mask: byte uses wdata[7:0], half uses wdata[15:0], word uses all 32 bits.
REQ-024 A load SHALL select the addressed lane(s), right-align them, and sign- or zero-extend per req_unsigned_i; word loads SHALL ignore req_unsigned_i.
REQ-025 An error SHALL be flagged for any of: size=11, half access with addr[0]=1, word access with addr[1:0]≠00, or addr[31:2]≥Depth.
REQ-026 On error the block SHALL set resp_err_o=1 and resp_rdata_o=0, leave memory unmodified, and keep the same latency.
REQ-027 A store SHALL commit to memory exactly once, on the WAIT→RESP (or IDLE→RESP) transition.
REQ-028 Request inputs SHALL be ignored outside IDLE.

Reset
REQ-029 With rst_ni=0 at a clock edge: state←IDLE, counter←0, req_ready_o=1 (after reset), resp_valid_o=0, resp_rdata_o=0, resp_err_o=0.
REQ-030 Reset during WAIT SHALL abort the access; a pending store SHALL NOT be committed.
REQ-031 Reset during RESP SHALL drop the response without a handshake.
REQ-032 Memory array contents SHALL NOT be reset.

Structure
REQ-033 The size encoding enum (SizeByte, SizeHalf, SizeWord) and the state enum SHALL live in shared package mem_pkg.
REQ-034 Lane selection plus extension SHALL be one sub-module, load_ext, which reuses the existing sign_ext module for byte and half sign extension.
REQ-035 The memory array SHALL be a flat logic array in dmem_responder, written with byte enables.

Verification
REQ-036 Store word 0xDEADBEEF @0x10, then load word @0x10 -> rdata 0xDEADBEEF, err 0, resp_valid at T+3 (WaitCycles=2).
REQ-037 After REQ-036, load byte signed @0x13 -> 0xFFFFFFDE; load byte unsigned @0x13 -> 0x000000DE; load half signed @0x10 -> 0xFFFFBEEF.
REQ-038 Store byte 0x55 @0x11 over 0xDEADBEEF, then load word @0x10 -> 0xDEAD55EF.
REQ-039 Load half @0x11, load word @0x12, size=11 @0x0, load word @0x400 (Depth=256) -> each err 1, rdata 0; a following word load @0x10 is unchanged.
REQ-040 Hold resp_ready_i=0 for 5 cycles -> resp_valid_o and data stable, req_ready_o=0; a req_valid_i pulse in that window is ignored.
REQ-041 Store word 0x12345678 @0x20 then rst_ni=0 in WAIT -> outputs reset next cycle; a later load @0x20 returns the prior contents, not 0x12345678.
